// File: rtl/subleq_pkg.sv
// Shared constants for the SUBLEQ execute sequencer: default widths, FSM encoding, field offsets.
// The HALTED state exists only when SUBLEQ_HALT_EN is defined.
package subleq_pkg;

  localparam int unsigned SUBLEQ_AW = 8;
  localparam int unsigned SUBLEQ_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_A   = 3'd1,
    ST_RD_B   = 3'd2,
    ST_WR_B   = 3'd3,
    ST_NEXT   = 3'd4
`ifdef SUBLEQ_HALT_EN
    , ST_HALTED = 3'd5
`endif
  } state_e;

  // Instruction layout is {A, B, C} with C in the low field.
  function automatic int unsigned a_lsb(input int unsigned aw);
    return 2 * aw;
  endfunction

  function automatic int unsigned b_lsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned c_lsb(input int unsigned aw);
    return 0 * aw;
  endfunction

endpackage

// File: rtl/subleq_next_pc.sv
// Next-PC select for SUBLEQ: branch to c when the result is zero or negative, else pc+1.
// With SUBLEQ_HALT_EN, also flags a taken branch to the all-ones address.
module subleq_next_pc #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] res,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] c,
  output logic [AW-1:0] pc_next,
  output logic          taken,
  output logic          halt
);

  assign taken   = (res == {DW{1'b0}}) || res[DW-1];
  assign pc_next = taken ? c : (pc + {{(AW-1){1'b0}}, 1'b1});

`ifdef SUBLEQ_HALT_EN
  assign halt = taken && (c == {AW{1'b1}});
`else
  assign halt = 1'b0;
`endif

endmodule

// File: rtl/subleq_exec.sv
// SUBLEQ execute sequencer: read mem[A], read mem[B], write mem[B]-mem[A] to B, strobe next PC.
// Optional SUBLEQ_HALT_EN: a taken branch to the all-ones address parks the block in HALTED.
module subleq_exec
  import subleq_pkg::*;
#(
  parameter int unsigned AW = SUBLEQ_AW,
  parameter int unsigned DW = SUBLEQ_DW
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3*AW-1:0] INSTR,
  input  logic [AW-1:0]   PC_IN,
  input  logic            START,
  output logic            BUSY,
  output logic [AW-1:0]   MEM_ADDR,
  output logic            MEM_RD,
  output logic            MEM_WR,
  output logic [DW-1:0]   MEM_WDATA,
  input  logic [DW-1:0]   MEM_RDATA,
  input  logic            MEM_ACK,
  output logic [AW-1:0]   PC_NEXT,
  output logic            PC_LOAD,
  output logic            HALT
);

  localparam int unsigned A_LSB = a_lsb(AW);
  localparam int unsigned B_LSB = b_lsb(AW);
  localparam int unsigned C_LSB = c_lsb(AW);

  state_e        state_r;
  logic [AW-1:0] a_r, b_r, c_r, pc_r;
  logic [DW-1:0] opa_r, opb_r, res_r;
  logic [DW-1:0] res_s;
  logic [AW-1:0] next_pc_s;
  logic          taken_s;
  logic          halt_s;
  logic          unused_s;

  assign res_s = opb_r - opa_r;

  subleq_next_pc #(.AW(AW), .DW(DW)) u_next_pc (
    .res     (res_r),
    .pc      (pc_r),
    .c       (c_r),
    .pc_next (next_pc_s),
    .taken   (taken_s),
    .halt    (halt_s)
  );

`ifdef SUBLEQ_HALT_EN
  assign unused_s = taken_s;
  assign HALT     = (state_r == ST_HALTED);
`else
  assign unused_s = taken_s ^ halt_s;
  assign HALT     = 1'b0;
`endif

  // Sequencer state and operand capture; memory ACK only matters while a request is up.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
      a_r     <= {AW{1'b0}};
      b_r     <= {AW{1'b0}};
      c_r     <= {AW{1'b0}};
      pc_r    <= {AW{1'b0}};
      opa_r   <= {DW{1'b0}};
      opb_r   <= {DW{1'b0}};
      res_r   <= {DW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            a_r     <= INSTR[A_LSB +: AW];
            b_r     <= INSTR[B_LSB +: AW];
            c_r     <= INSTR[C_LSB +: AW];
            pc_r    <= PC_IN;
            state_r <= ST_RD_A;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_A: begin
          if (MEM_ACK) begin
            opa_r   <= MEM_RDATA;
            state_r <= ST_RD_B;
          end else begin
            state_r <= ST_RD_A;
          end
        end
        ST_RD_B: begin
          if (MEM_ACK) begin
            opb_r   <= MEM_RDATA;
            state_r <= ST_WR_B;
          end else begin
            state_r <= ST_RD_B;
          end
        end
        ST_WR_B: begin
          if (MEM_ACK) begin
            res_r   <= res_s;
            state_r <= ST_NEXT;
          end else begin
            state_r <= ST_WR_B;
          end
        end
        ST_NEXT: begin
`ifdef SUBLEQ_HALT_EN
          if (halt_s) begin
            state_r <= ST_HALTED;
          end else begin
            state_r <= ST_IDLE;
          end
`else
          state_r <= ST_IDLE;
`endif
        end
`ifdef SUBLEQ_HALT_EN
        ST_HALTED: begin
          state_r <= ST_HALTED;
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Moore decode: outputs depend only on flops, so reset clears them without waiting for a clock.
  always_comb begin
    BUSY      = 1'b0;
    MEM_ADDR  = {AW{1'b0}};
    MEM_RD    = 1'b0;
    MEM_WR    = 1'b0;
    MEM_WDATA = {DW{1'b0}};
    PC_NEXT   = {AW{1'b0}};
    PC_LOAD   = 1'b0;
    case (state_r)
      ST_RD_A: begin
        BUSY     = 1'b1;
        MEM_RD   = 1'b1;
        MEM_ADDR = a_r;
      end
      ST_RD_B: begin
        BUSY     = 1'b1;
        MEM_RD   = 1'b1;
        MEM_ADDR = b_r;
      end
      ST_WR_B: begin
        BUSY      = 1'b1;
        MEM_WR    = 1'b1;
        MEM_ADDR  = b_r;
        MEM_WDATA = res_s;
      end
      ST_NEXT: begin
        BUSY    = 1'b1;
        PC_LOAD = 1'b1;
        PC_NEXT = next_pc_s;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_subleq_exec.sv
// Scoreboard bench for subleq_exec with a wait-state memory model; SUBLEQ_HALT_EN selects the halt checks.
module tb_subleq_exec;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [23:0] INSTR = 24'h000000;
  logic [7:0]  PC_IN = 8'h00;
  logic        START = 1'b0;
  logic        BUSY;
  logic [7:0]  MEM_ADDR;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA;
  logic        mem_ack;
  logic [7:0]  PC_NEXT;
  logic        PC_LOAD;
  logic        HALT;

  logic [7:0]  mem [0:255];
  int          wait_n = 0;
  int          wcnt = 0;
  logic        stray_ack = 1'b0;
  logic        hold_chk = 1'b0;
  logic [7:0]  hold_addr = 8'h00;

  int          checks = 0;
  int          failures = 0;
  int          load_cnt = 0;
  int          exp_loads = 0;
  logic [7:0]  exp_pc_q [$];
  wr_t         exp_wr_q [$];

  subleq_exec dut (
    .CLK       (CLK),
    .RST       (RST),
    .INSTR     (INSTR),
    .PC_IN     (PC_IN),
    .START     (START),
    .BUSY      (BUSY),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_RD    (MEM_RD),
    .MEM_WR    (MEM_WR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA),
    .MEM_ACK   (mem_ack),
    .PC_NEXT   (PC_NEXT),
    .PC_LOAD   (PC_LOAD),
    .HALT      (HALT)
  );

  always #5 CLK = ~CLK;

  assign mem_ack   = ((MEM_RD || MEM_WR) && (wcnt == wait_n)) || stray_ack;
  assign MEM_RDATA = mem[MEM_ADDR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: counts wait cycles, commits writes, remembers the address of a pending request.
  always @(posedge CLK) begin
    if ((MEM_RD || MEM_WR) && !mem_ack) begin
      wcnt      <= wcnt + 1;
      hold_chk  <= 1'b1;
      hold_addr <= MEM_ADDR;
    end else begin
      wcnt     <= 0;
      hold_chk <= 1'b0;
    end
    if (MEM_WR && mem_ack) mem[MEM_ADDR] <= MEM_WDATA;
  end

  // Monitor: pops expectations whenever the DUT strobes a PC or completes a write.
  always @(negedge CLK) begin
    if (PC_LOAD) begin
      load_cnt++;
      check("pc_load_expected", 32'(exp_pc_q.size() != 0), 32'd1);
      if (exp_pc_q.size() != 0) check("pc_next", 32'(PC_NEXT), 32'(exp_pc_q.pop_front()));
      check("halt_low_in_next", 32'(HALT), 32'd0);
    end
    if (MEM_WR && mem_ack) begin
      check("write_expected", 32'(exp_wr_q.size() != 0), 32'd1);
      if (exp_wr_q.size() != 0) begin
        wr_t e;
        e = exp_wr_q.pop_front();
        check("wr_addr", 32'(MEM_ADDR), 32'(e.addr));
        check("wr_data", 32'(MEM_WDATA), 32'(e.data));
        check("rd_wr_exclusive", 32'(MEM_RD), 32'd0);
      end
    end
    if (hold_chk && RST) begin
      check("hold_addr", 32'(MEM_ADDR), 32'(hold_addr));
      check("hold_req", 32'(MEM_RD || MEM_WR), 32'd1);
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] pc, input int w, input logic [7:0] exp_wd,
                        input logic [7:0] exp_pc, input bit noise);
    int  n;
    bit  got;
    bit  poked;
    wr_t e;
    e.addr = b;
    e.data = exp_wd;
    exp_wr_q.push_back(e);
    exp_pc_q.push_back(exp_pc);
    exp_loads++;
    @(negedge CLK);
    wait_n = w;
    INSTR  = {a, b, c};
    PC_IN  = pc;
    START  = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    INSTR = 24'h5A5A5A;
    n = 0;
    got = 1'b0;
    poked = 1'b0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(posedge CLK);
      #1;
      START = 1'b0;
      if (PC_LOAD) begin
        got = 1'b1;
        n = i;
      end else if (noise && !poked && MEM_RD && MEM_ADDR == b) begin
        INSTR = {8'h77, 8'h78, 8'h79};
        START = 1'b1;
        poked = 1'b1;
      end
    end
    check("latency", 32'(n), 32'(3 + 3 * w));
    if (noise) begin
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      check("start_in_next_ignored", 32'(BUSY), 32'd0);
    end
    @(posedge CLK);
    #1;
    check("idle_after_op", 32'(BUSY), 32'd0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    #12;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_rd", 32'(MEM_RD), 32'd0);
    check("rst_wr", 32'(MEM_WR), 32'd0);
    check("rst_addr", 32'(MEM_ADDR), 32'd0);
    check("rst_wdata", 32'(MEM_WDATA), 32'd0);
    check("rst_pc_load", 32'(PC_LOAD), 32'd0);
    check("rst_pc_next", 32'(PC_NEXT), 32'd0);
    check("rst_halt", 32'(HALT), 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Negative result: 3-5 = 0xFE, branch taken to 0x40.
    mem[8'h10] = 8'h05;
    mem[8'h11] = 8'h03;
    run_op(8'h10, 8'h11, 8'h40, 8'h02, 0, 8'hFE, 8'h40, 1'b0);

    // Positive result with two wait cycles per access: 7-1 = 6, fall through to 0x03.
    mem[8'h10] = 8'h01;
    mem[8'h11] = 8'h07;
    run_op(8'h10, 8'h11, 8'h40, 8'h02, 2, 8'h06, 8'h03, 1'b0);

    // Zero result branches; positive result at PC 0xFF wraps to 0x00.
    mem[8'h20] = 8'h2A;
    mem[8'h21] = 8'h2A;
    run_op(8'h20, 8'h21, 8'h20, 8'h05, 0, 8'h00, 8'h20, 1'b0);
    mem[8'h30] = 8'h01;
    mem[8'h31] = 8'h09;
    run_op(8'h30, 8'h31, 8'h50, 8'hFF, 0, 8'h08, 8'h00, 1'b0);

    // Stray ACK in IDLE, then START pulses during RD_B and NEXT: 6-1 = 5 -> 0x08.
    @(negedge CLK);
    stray_ack = 1'b1;
    @(posedge CLK);
    #1;
    stray_ack = 1'b0;
    check("stray_ack_idle_busy", 32'(BUSY), 32'd0);
    check("stray_ack_idle_rd", 32'(MEM_RD), 32'd0);
    run_op(8'h10, 8'h11, 8'h60, 8'h07, 1, 8'h05, 8'h08, 1'b1);

    // Asynchronous reset while RD_B is waiting.
    mem[8'h40] = 8'h03;
    mem[8'h41] = 8'h03;
    @(negedge CLK);
    wait_n = 3;
    INSTR  = {8'h40, 8'h41, 8'h70};
    PC_IN  = 8'h10;
    START  = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (MEM_RD && MEM_ADDR == 8'h41) found = 1'b1;
      else begin
        @(posedge CLK);
        #1;
      end
    end
    check("reach_rd_b", 32'(found), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check("async_rst_rd", 32'(MEM_RD), 32'd0);
    check("async_rst_busy", 32'(BUSY), 32'd0);
    check("async_rst_pc_load", 32'(PC_LOAD), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    run_op(8'h40, 8'h41, 8'h70, 8'h10, 0, 8'h00, 8'h70, 1'b0);

    // Taken branch to 0xFF: 3-5 = 0xFE.
    mem[8'h50] = 8'h05;
    mem[8'h51] = 8'h03;
    run_op(8'h50, 8'h51, 8'hFF, 8'h09, 0, 8'hFE, 8'hFF, 1'b0);
`ifdef SUBLEQ_HALT_EN
    check("halted_halt", 32'(HALT), 32'd1);
    @(negedge CLK);
    INSTR = {8'h10, 8'h11, 8'h40};
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("halted_start_ignored_rd", 32'(MEM_RD), 32'd0);
    check("halted_busy", 32'(BUSY), 32'd0);
    check("halted_stays", 32'(HALT), 32'd1);
`else
    check("no_halt_feature", 32'(HALT), 32'd0);
    mem[8'h60] = 8'h02;
    mem[8'h61] = 8'h01;
    run_op(8'h60, 8'h61, 8'h33, 8'h0A, 0, 8'hFF, 8'h33, 1'b0);
`endif

    repeat (3) @(posedge CLK);
    #1;
    check("pc_load_count", 32'(load_cnt), 32'(exp_loads));
    check("pc_queue_drained", 32'(exp_pc_q.size()), 32'd0);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/subleq_exec.md
Name: subleq_exec

Overview:
- Execute sequencer directly downstream of the 24-bit instruction register (ireg_24).
- Takes the latched SUBLEQ instruction {A,B,C} and performs the full step: read mem[A], read mem[B], write mem[B]-mem[A] back to B, then select the next PC.
- Talks to data memory over a request/acknowledge handshake and hands the next PC to the fetch stage.

Parameters:
- AW, 8, address/field width; instruction width is 3*AW (A=[3AW-1:2AW], B=[2AW-1:AW], C=[AW-1:0]).
- DW, 8, data word width; operands and results are two's complement.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- INSTR  in  3*AW  instruction from ireg_24 instr_out.
- PC_IN  in  AW  address of the current instruction.
- START  in  1  one-cycle pulse: begin executing INSTR.
- BUSY  out  1  high in any state other than IDLE (and HALTED).
- MEM_ADDR  out  AW  memory address.
- MEM_RD  out  1  read request, held until acked.
- MEM_WR  out  1  write request, held until acked.
- MEM_WDATA  out  DW  write data.
- MEM_RDATA  in  DW  read data, valid when MEM_ACK is high.
- MEM_ACK  in  1  memory acknowledge; may be high in the same cycle the request first appears.
- PC_NEXT  out  AW  next PC, valid while PC_LOAD is high.
- PC_LOAD  out  1  one-cycle strobe; fetch loads PC_NEXT.
- HALT  out  1  halted indicator (feature only; tied 0 otherwise).

Behaviour:
- Reset (RST low, asynchronous): state=IDLE; all outputs 0; internal registers (a,b,c,pc,opa,opb,res) cleared.
- Reset mid-operation: outstanding MEM_RD/MEM_WR drop immediately and the transaction is abandoned; no PC_LOAD is issued.
- FSM states: IDLE, RD_A, RD_B, WR_B, NEXT (plus HALTED with the feature).
- IDLE: on START=1, latch INSTR fields and PC_IN, then go to RD_A. INSTR may change after this edge.
  - START outside IDLE is ignored.
  - MEM_ACK in IDLE is ignored.
- Memory outputs are decoded from the state register (Moore). MEM_ACK is sampled on the rising edge while a request is high.
- RD_A: MEM_RD=1, MEM_ADDR=a. On ACK, opa<=MEM_RDATA and go to RD_B; otherwise stay.
- RD_B: MEM_RD=1, MEM_ADDR=b. On ACK, opb<=MEM_RDATA and go to WR_B.
- WR_B:
  - res = opb - opa, modulo 2^DW (wrap, no saturation).
  - MEM_WR=1, MEM_ADDR=b, MEM_WDATA=res.
  - On ACK, go to NEXT.
- NEXT (exactly one cycle):
  - PC_LOAD=1.
  - PC_NEXT=c if res is zero or negative (MSB=1); otherwise pc+1 modulo 2^AW (0xFF+1 = 0x00).
  - Then return to IDLE.
- MEM_RD and MEM_WR are never high together. MEM_WDATA is 0 outside WR_B.
- Latency with zero-wait memory (ACK in the first request cycle): START sampled at edge 0, PC_LOAD high in the cycle after edge 3. Each extra wait cycle adds one cycle.
- START may arrive in the same cycle PC_LOAD is high (state is still NEXT); it is ignored.

Optional Feature:
- Macro: SUBLEQ_HALT_EN.
- Defined: in NEXT, a taken branch with c = all-ones (0xFF) goes to HALTED instead of IDLE.
  - PC_LOAD still pulses, with PC_NEXT=0xFF.
  - HALT=1 and BUSY=0 while halted; START is ignored.
  - Only reset leaves HALTED.
- Not defined: no HALTED state; HALT is tied 0; a branch to 0xFF behaves like any other taken branch.

Decomposition:
- Package subleq_pkg: state encoding constants, instruction field position constants (A/B/C offsets derived from AW), default AW/DW.
- Sub-module subleq_next_pc: combinational; inputs res, pc, c; outputs the PC_NEXT value and a taken flag (the halt-address compare lives here when the feature is enabled). It is instantiated once in subleq_exec.

Test Plan:
- Negative result: mem[0x10]=5, mem[0x11]=3, INSTR={0x10,0x11,0x40}, PC_IN=0x02, zero-wait memory -> write 0xFE to 0x11; PC_LOAD with PC_NEXT=0x40 in the 4th cycle after START.
- Positive result: mem[0x10]=1, mem[0x11]=7, INSTR={0x10,0x11,0x40}, PC_IN=0x02, ACK delayed 2 cycles per access -> write 0x06; PC_NEXT=0x03 in the 10th cycle after START; MEM_ADDR and request held stable through each wait.
- Zero and PC wrap:
  - mem[A]=mem[B]=0x2A, C=0x20 -> write 0x00, PC_NEXT=0x20.
  - Separately, positive result with PC_IN=0xFF -> PC_NEXT=0x00.
- Ignored inputs: START pulses during RD_B and during NEXT, plus stray MEM_ACK in IDLE -> no state change, exactly one PC_LOAD per accepted START.
- Reset mid-op: RST low while in RD_B with MEM_RD high -> MEM_RD, BUSY, PC_LOAD go 0 asynchronously; after release, next START runs normally.
- SUBLEQ_HALT_EN: INSTR={0x10,0x11,0xFF} with a negative result -> PC_LOAD with PC_NEXT=0xFF, HALT=1 stays high, later START ignored. Without the macro, same stimulus -> HALT=0 and the block returns to IDLE.
